// File: rtl/dbuf_filt_multi.sv
// rtl/dbuf_filt_multi.sv - multi-channel synchronising glitch-filter buffer with edge-event pulses
module dbuf_filt_multi #(
  parameter int             NCH      = 4,
  parameter int             FILT_CNT = 3,
  parameter logic [NCH-1:0] INV_MASK = '0,
  parameter logic [NCH-1:0] RST_VAL  = '0
) (
  input  logic           CELCLK,
  input  logic           CELRSTN,
  input  logic           CELV,
  input  logic           CELG,
  input  logic           SUB,
  input  logic           en,
  input  logic [NCH-1:0] i,
  output logic [NCH-1:0] o,
  output logic [NCH-1:0] rise,
  output logic [NCH-1:0] fall
);

  localparam int             CW       = (FILT_CNT > 1) ? $clog2(FILT_CNT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILT_CNT - 1);

  logic [NCH-1:0] ff1;
  logic [NCH-1:0] ff2;
  logic [NCH-1:0] s;
  logic [CW-1:0]  cnt [NCH];

  // Supply pins are carried through the brick boundary only; no logic depends on them.
  logic unused_supply;
  assign unused_supply = ^{CELV, CELG, SUB};

  assign s = ff2 ^ INV_MASK;

  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      ff1 <= RST_VAL;
      ff2 <= RST_VAL;
    end else begin
      ff1 <= i;
      ff2 <= ff1;
    end
  end

  // Each channel commits s to o only after FILT_CNT consecutive disagreeing edges.
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      o    <= RST_VAL;
      rise <= '0;
      fall <= '0;
      for (int n = 0; n < NCH; n++) begin
        cnt[n] <= '0;
      end
    end else begin
      rise <= '0;
      fall <= '0;
      for (int n = 0; n < NCH; n++) begin
        if (!en || (s[n] == o[n])) begin
          cnt[n] <= '0;
        end else if (cnt[n] == CNT_LAST) begin
          o[n]    <= s[n];
          rise[n] <= s[n];
          fall[n] <= ~s[n];
          cnt[n]  <= '0;
        end else begin
          cnt[n] <= cnt[n] + 1'b1;
        end
      end
    end
  end

endmodule
